// File: rtl/mem_port_arbiter_if.sv
// Shared RAM port bundle: IF fetch side, MEM data side and the RAM itself.
// The arbiter takes the slave view; the pipeline/RAM environment takes master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ack;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_ack, if_valid, if_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_valid, mem_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_ack, if_valid, if_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_valid, mem_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared by fetch and memory stages: MEM-priority grant with
// an IF anti-starvation override, 1-cycle read return routed to its owner.
module mem_port_arbiter #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 16,
  parameter logic [DATA_W-1:0] NOP_WORD     = '0,
  parameter int                STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    NONE,
    IF_RD,
    MEM_RD
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_t            pend_q, pend_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              force_if;
  logic              grant_if;
  logic              grant_mem;

  // Acks are held low while reset is asserted, not just after it.
  assign force_if  = bus.if_req && (starve_q == LIMIT);
  assign grant_if  = !rst && bus.if_req && (!bus.mem_req || force_if);
  assign grant_mem = !rst && bus.mem_req && !grant_if;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= NONE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      pend_q   <= pend_d;
      starve_q <= starve_d;
      addr_q   <= bus.ram_addr;
      wdata_q  <= bus.ram_wdata;
    end
  end

  always_comb begin
    pend_d        = NONE;
    bus.if_ack    = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.ram_addr  = addr_q;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = wdata_q;
    unique case (1'b1)
      grant_if: begin
        pend_d       = IF_RD;
        bus.if_ack   = 1'b1;
        bus.ram_addr = bus.if_addr;
      end
      grant_mem: begin
        pend_d        = bus.mem_we ? NONE : MEM_RD;
        bus.mem_ack   = 1'b1;
        bus.ram_addr  = bus.mem_addr;
        bus.ram_we    = bus.mem_we;
        bus.ram_wdata = bus.mem_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.if_req || grant_if)
      starve_d = '0;
    else if (starve_q < LIMIT)
      starve_d = starve_q + 4'd1;
  end

  always_comb begin
    bus.if_valid  = (pend_q == IF_RD) && !bus.if_flush;
    bus.if_rdata  = bus.if_valid ? bus.ram_rdata : NOP_WORD;
    bus.mem_valid = (pend_q == MEM_RD);
    bus.mem_rdata = bus.mem_valid ? bus.ram_rdata : '0;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Clocked arbiter that shares the single physical RAM port between the Instruction Fetch (IF) and MEMory (MEM) stages. RAM reads have 1-cycle latency.
- Grants one requester per cycle with MEM priority and an IF anti-starvation override.
- Tracks the owner of the in-flight read and routes returned data to that owner.
- Feeds the NOP constant to IF whenever IF has no valid fetch data; sits between the pipeline stages and the RAM model.

Parameters:
- ADDR_W, 16, RAM address width (matches `RAMADDR_WIDTH).
- DATA_W, 16, RAM data width (matches `RAMREAD_WIDTH).
- NOP_WORD, 16'h0000, instruction word driven to IF when no fetch data is valid (matches `CONST_NOP).
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock, all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF requests a fetch; held with if_addr until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  discard any IF read response returning this cycle (taken branch).
- if_ack  out  1  IF request issued to RAM this cycle.
- if_valid  out  1  if_rdata holds fetched data this cycle.
- if_rdata  out  DATA_W  fetched word, or NOP_WORD when if_valid=0.
- mem_req  in  1  MEM requests access; held with addr/we/wdata until mem_ack.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- mem_ack  out  1  MEM request issued to RAM this cycle.
- mem_valid  out  1  mem_rdata holds read data this cycle.
- mem_rdata  out  DATA_W  read data, or 0 when mem_valid=0.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data for the address issued in the previous cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are clk and rst.
- Reset state: pend_owner=NONE, starve_cnt=0.
- Reset outputs: if_valid=0, mem_valid=0, if_rdata=NOP_WORD, mem_rdata=0, if_ack=0, mem_ack=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Arbitration is combinational within the cycle. Default is MEM wins when both request.
- Override: if starve_cnt==STARVE_LIMIT and if_req=1, IF wins over MEM.
- Grant IF: if_ack=1, ram_addr=if_addr, ram_we=0.
- Grant MEM: mem_ack=1, ram_addr=mem_addr, ram_we=mem_we, ram_wdata=mem_wdata.
- No grant: ram_we=0, ram_addr holds its last value, both acks are 0.
- pend_owner register, states NONE / IF_RD / MEM_RD. Next value is IF_RD on an IF grant, MEM_RD on a MEM read grant, NONE otherwise (covers MEM write and idle).
- Read responses (latency exactly 1 cycle after ack):
  - if_valid = (pend_owner==IF_RD) && !if_flush. if_rdata = if_valid ? ram_rdata : NOP_WORD.
  - mem_valid = (pend_owner==MEM_RD). mem_rdata = mem_valid ? ram_rdata : 0.
- Back-to-back: a new grant may issue in the same cycle a response returns, giving full throughput of 1 access/cycle.
- starve_cnt:
  - Cleared when if_req=0 or IF is granted.
  - Incremented when if_req=1 and IF is denied.
  - Saturates at STARVE_LIMIT.
- MEM writes complete in the ack cycle and produce no mem_valid.
- if_flush affects only the response returning in that cycle. An IF grant in the same cycle is unaffected and its response is valid next cycle unless flushed again.
- Requests with req=0 are ignored regardless of address or data values.
- Reset mid-read: the in-flight response is dropped, and no valid is asserted in the first cycle after rst falls.

Test Plan:
- IF only: if_req=1, if_addr=0x0010, ram returns 0x1234 -> if_ack same cycle, next cycle if_valid=1, if_rdata=0x1234, mem_valid=0.
- Conflict: both req, mem_we=0, mem_addr=0x0200 -> mem_ack=1, if_ack=0, ram_addr=0x0200. Next cycle mem_valid=1 with ram_rdata, if_rdata=NOP_WORD.
- Starvation: mem_req and if_req held high, STARVE_LIMIT=4 -> MEM acked cycles 0-3, IF acked cycle 4, MEM cycle 5, starve_cnt back to 0 after cycle 4.
- Write: mem_req=1, mem_we=1, addr 0x0040, wdata 0xBEEF -> ram_we=1, ram_wdata=0xBEEF in ack cycle, no mem_valid next cycle.
- Flush: IF ack at cycle N, if_flush=1 at N+1 together with new IF ack -> if_valid=0 and if_rdata=NOP_WORD at N+1, if_valid=1 at N+2.
- Reset mid-read: MEM read acked, rst pulsed asynchronously before next edge -> mem_valid=0 and all outputs at reset values, no stale valid after release.
